rom_arbiter: RTL and testbench

- Shares one single-port synchronous instruction/constant ROM between two requesters: port A (instruction fetch) and port B (data/constant load).
- Round-robin arbitration with a valid/ready request handshake.
- Fully pipelined: one ROM read can be issued per cycle. Requester ID is tracked through the ROM's 1-cycle read latency and each response is returned to the correct port.
- Sits between the CPU fetch/load units and the ROM. Per-port grant counters are kept for performance debug.

---
 rtl/rom_arbiter.sv | 116 +++++++++++
 tb/tb_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ROM between a fetch port (A)
// and a load port (B), with requester IDs carried through the ROM read latency.
module rom_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  a_req_valid,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  output logic                  a_req_ready,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_resp_data,

  input  logic                  b_req_valid,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_req_ready,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_resp_data,

  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data_in,

  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  a_grant_count,
  output logic [CNT_WIDTH-1:0]  b_grant_count,
  output logic                  busy
);

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  port_e last_grant;
  port_e s1_id;
  port_e s2_id;
  logic  s1_valid;
  logic  s2_valid;
  logic  grant_a;
  logic  grant_b;
  logic  accept;

  // On a tie the port that did not win last time gets the ROM.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_req_valid && b_req_valid) begin
      grant_a = (last_grant == PortB);
      grant_b = (last_grant == PortA);
    end else begin
      grant_a = a_req_valid;
      grant_b = b_req_valid;
    end
  end

  assign accept      = grant_a | grant_b;
  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign busy        = s1_valid | s2_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PortB;
      rom_addr   <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= PortA;
      s2_valid   <= 1'b0;
      s2_id      <= PortA;
    end else begin
      s1_valid <= accept;
      if (grant_a) begin
        rom_addr   <= a_req_addr;
        last_grant <= PortA;
        s1_id      <= PortA;
      end else if (grant_b) begin
        rom_addr   <= b_req_addr;
        last_grant <= PortB;
        s1_id      <= PortB;
      end
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  // ROM data for the stage-2 read is present on rom_data_in now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
      a_resp_data  <= '0;
      b_resp_data  <= '0;
    end else begin
      a_resp_valid <= s2_valid && (s2_id == PortA);
      b_resp_valid <= s2_valid && (s2_id == PortB);
      if (s2_valid && (s2_id == PortA)) a_resp_data <= rom_data_in;
      if (s2_valid && (s2_id == PortB)) b_resp_data <= rom_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_grant_count <= '0;
      b_grant_count <= '0;
    end else if (cnt_clear) begin
      a_grant_count <= '0;
      b_grant_count <= '0;
    end else begin
      if (grant_a && (a_grant_count != {CNT_WIDTH{1'b1}})) a_grant_count <= a_grant_count + 1'b1;
      if (grant_b && (b_grant_count != {CNT_WIDTH{1'b1}})) b_grant_count <= b_grant_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered ROM model returning addr ^ 32'hA5A50000.
module tb_rom_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req_valid = 1'b0;
  logic [AW-1:0] a_req_addr = '0;
  logic          a_req_ready;
  logic          a_resp_valid;
  logic [DW-1:0] a_resp_data;
  logic          b_req_valid = 1'b0;
  logic [AW-1:0] b_req_addr = '0;
  logic          b_req_ready;
  logic          b_resp_valid;
  logic [DW-1:0] b_resp_data;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data_in = '0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] a_grant_count;
  logic [CW-1:0] b_grant_count;
  logic          busy;

  int checks = 0;
  int passes = 0;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .a_req_valid  (a_req_valid),
    .a_req_addr   (a_req_addr),
    .a_req_ready  (a_req_ready),
    .a_resp_valid (a_resp_valid),
    .a_resp_data  (a_resp_data),
    .b_req_valid  (b_req_valid),
    .b_req_addr   (b_req_addr),
    .b_req_ready  (b_req_ready),
    .b_resp_valid (b_resp_valid),
    .b_resp_data  (b_resp_data),
    .rom_addr     (rom_addr),
    .rom_data_in  (rom_data_in),
    .cnt_clear    (cnt_clear),
    .a_grant_count(a_grant_count),
    .b_grant_count(b_grant_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data_in <= {{(DW-AW){1'b0}}, rom_addr} ^ 32'hA5A50000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rom_val(input int addr);
    rom_val = 32'hA5A50000 ^ DW'(addr);
  endfunction

  initial begin
    #2;
    check("reset_rom_addr", 64'(rom_addr), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_resp_valid", 64'({a_resp_valid, b_resp_valid}), 64'h0);
    check("reset_resp_data", 64'({a_resp_data, b_resp_data}), 64'h0);
    check("reset_counts", 64'({a_grant_count, b_grant_count}), 64'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic read
    a_req_valid = 1'b1;
    a_req_addr  = 8'h01;
    #1;
    check("basic_a_ready", 64'(a_req_ready), 64'h1);
    check("basic_b_ready", 64'(b_req_ready), 64'h0);
    tick();
    a_req_valid = 1'b0;
    check("basic_rom_addr", 64'(rom_addr), 64'h01);
    check("basic_busy", 64'(busy), 64'h1);
    check("basic_count", 64'(a_grant_count), 64'h1);
    check("basic_resp_early1", 64'(a_resp_valid), 64'h0);
    tick();
    check("basic_resp_early2", 64'(a_resp_valid), 64'h0);
    tick();
    check("basic_resp_valid", 64'(a_resp_valid), 64'h1);
    check("basic_resp_data", 64'(a_resp_data), 64'hA5A50001);
    check("basic_b_resp", 64'(b_resp_valid), 64'h0);
    tick();
    check("basic_resp_pulse", 64'(a_resp_valid), 64'h0);
    check("basic_busy_end", 64'(busy), 64'h0);

    // Round-robin with both ports held valid
    do_reset();
    a_req_addr = 8'h10;
    b_req_addr = 8'h20;
    for (int n = 0; n < 9; n++) begin
      a_req_valid = (n < 6);
      b_req_valid = (n < 6);
      #1;
      if (n < 6) begin
        check($sformatf("rr_a_ready%0d", n), 64'(a_req_ready), 64'((n % 2) == 0));
        check($sformatf("rr_b_ready%0d", n), 64'(b_req_ready), 64'((n % 2) == 1));
      end
      tick();
      if (n >= 2 && n < 8) begin
        check($sformatf("rr_a_resp%0d", n), 64'(a_resp_valid), 64'(((n - 2) % 2) == 0));
        check($sformatf("rr_b_resp%0d", n), 64'(b_resp_valid), 64'(((n - 2) % 2) == 1));
        if (((n - 2) % 2) == 0) check($sformatf("rr_a_data%0d", n), 64'(a_resp_data), 64'(rom_val(8'h10)));
        else check($sformatf("rr_b_data%0d", n), 64'(b_resp_data), 64'(rom_val(8'h20)));
      end
    end
    check("rr_a_count", 64'(a_grant_count), 64'h3);
    check("rr_b_count", 64'(b_grant_count), 64'h3);

    // Back-to-back reads from A alone
    for (int n = 0; n < 8; n++) begin
      a_req_valid = (n < 5);
      a_req_addr  = AW'(n);
      tick();
      check($sformatf("b2b_busy%0d", n), 64'(busy), 64'(n <= 5));
      check($sformatf("b2b_a_resp%0d", n), 64'(a_resp_valid), 64'(n >= 2 && n <= 6));
      check($sformatf("b2b_b_resp%0d", n), 64'(b_resp_valid), 64'h0);
      if (n >= 2 && n <= 6) check($sformatf("b2b_data%0d", n), 64'(a_resp_data), 64'(rom_val(n - 2)));
    end

    // Interleaved IDs: A@05, B@06, A@07
    for (int n = 0; n < 6; n++) begin
      a_req_valid = (n == 0) || (n == 2);
      b_req_valid = (n == 1);
      a_req_addr  = AW'(5 + n);
      b_req_addr  = AW'(5 + n);
      tick();
      check($sformatf("il_a_resp%0d", n), 64'(a_resp_valid), 64'((n == 2) || (n == 4)));
      check($sformatf("il_b_resp%0d", n), 64'(b_resp_valid), 64'(n == 3));
      if (n == 2 || n == 4) check($sformatf("il_a_data%0d", n), 64'(a_resp_data), 64'(rom_val(5 + n - 2)));
      if (n == 3) check("il_b_data", 64'(b_resp_data), 64'(rom_val(6)));
    end

    // Counter saturation and clear priority
    do_reset();
    a_req_valid = 1'b1;
    a_req_addr  = 8'h02;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 14) check("sat_count14", 64'(a_grant_count), 64'd14);
      if (n == 15) check("sat_count15", 64'(a_grant_count), 64'd15);
    end
    check("sat_count17", 64'(a_grant_count), 64'd15);
    cnt_clear = 1'b1;
    #1;
    check("clr_a_ready", 64'(a_req_ready), 64'h1);
    tick();
    cnt_clear = 1'b0;
    check("clr_count", 64'(a_grant_count), 64'h0);
    tick();
    a_req_valid = 1'b0;
    check("clr_count_after", 64'(a_grant_count), 64'h1);
    check("clr_b_count", 64'(b_grant_count), 64'h0);
    tick();
    tick();
    tick();

    // Reset while a read is in flight
    a_req_valid = 1'b1;
    a_req_addr  = 8'h03;
    tick();
    a_req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_rom_addr", 64'(rom_addr), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_counts", 64'({a_grant_count, b_grant_count}), 64'h0);
    tick();
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("rst_no_resp%0d", n), 64'({a_resp_valid, b_resp_valid}), 64'h0);
    end
    check("rst_busy_after", 64'(busy), 64'h0);
    a_req_valid = 1'b1;
    b_req_valid = 1'b1;
    #1;
    check("rst_tie_a", 64'(a_req_ready), 64'h1);
    check("rst_tie_b", 64'(b_req_ready), 64'h0);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
